// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and defaults for the pipeline hazard/stall controller and
// its load-use compare sub-block.
//   DFLT_REG_W    : default register-index width
//   DFLT_ZERO_REG : default hardwired-zero register index
//   state_e       : controller FSM states
//   ctrl_t        : bundle of the per-stage enable/bubble/flush controls
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam int DFLT_REG_W    = 5;
  localparam int DFLT_ZERO_REG = 31;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic id_ex_bubble;
    logic if_id_flush;
  } ctrl_t;

  // Builds a control bundle with every register-bank enable set to 'en'.
  function automatic ctrl_t mk_ctrl(input logic en, input logic bubble,
                                    input logic flush);
    ctrl_t c;
    c.pc_en        = en;
    c.if_id_en     = en;
    c.id_ex_en     = en;
    c.ex_mem_en    = en;
    c.mem_wb_en    = en;
    c.id_ex_bubble = bubble;
    c.if_id_flush  = flush;
    return c;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use hazard compare between the instruction in
// EX (a load writing ex_rd) and the source registers of the instruction in
// ID. The hardwired-zero register is never a hazard source.
//   i_id_rn        : first source register of the ID instruction
//   i_id_rm        : second source register of the ID instruction
//   i_id_uses_rm   : ID instruction actually reads i_id_rm
//   i_ex_mem_read  : EX instruction is a load
//   i_ex_rd        : destination register of the EX instruction
//   o_hazard       : ID must stall one cycle behind the load
// ---------------------------------------------------------------------------
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W    = DFLT_REG_W,
  parameter int ZERO_REG = DFLT_ZERO_REG
) (
  input  logic [REG_W-1:0] i_id_rn,
  input  logic [REG_W-1:0] i_id_rm,
  input  logic             i_id_uses_rm,
  input  logic             i_ex_mem_read,
  input  logic [REG_W-1:0] i_ex_rd,
  output logic             o_hazard
);

  localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

  logic w_rd_valid;
  logic w_rn_match;
  logic w_rm_match;

  assign w_rd_valid = i_ex_mem_read && (i_ex_rd != ZERO_IDX);
  assign w_rn_match = (i_ex_rd == i_id_rn);
  // An unused rm field may hold garbage, so it only counts when read.
  assign w_rm_match = i_id_uses_rm && (i_ex_rd == i_id_rm);
  assign o_hazard   = w_rd_valid && (w_rn_match || w_rm_match);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl
// Hazard and stall controller for the five-stage pipeline. Produces the
// register-bank enables plus ID/EX bubble and IF/ID flush combinationally,
// so a stall acts in the cycle it is detected. Priority is
// mem_busy > taken branch / flush window > load-use.
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_id_rn/rm/uses_rm    : ID source register fields
//   i_ex_mem_read, i_ex_rd: EX load indication and destination
//   i_br_taken            : branch resolved taken in EX
//   i_mem_busy            : data memory not ready, MEM must hold
//   o_*_en                : pipeline register-bank enables
//   o_id_ex_bubble        : load NOP into ID/EX
//   o_if_id_flush         : load NOP into IF/ID
//   o_stall_cnt           : saturating count of cycles with pc_en low
//   o_mem_timeout         : sticky, mem_busy lasted MEM_TIMEOUT cycles
// ---------------------------------------------------------------------------
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W        = DFLT_REG_W,
  parameter int ZERO_REG     = DFLT_ZERO_REG,
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [REG_W-1:0] i_id_rn,
  input  logic [REG_W-1:0] i_id_rm,
  input  logic             i_id_uses_rm,
  input  logic             i_ex_mem_read,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_br_taken,
  input  logic             i_mem_busy,
  output logic             o_pc_en,
  output logic             o_if_id_en,
  output logic             o_id_ex_en,
  output logic             o_ex_mem_en,
  output logic             o_mem_wb_en,
  output logic             o_id_ex_bubble,
  output logic             o_if_id_flush,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic             o_mem_timeout
);

  localparam int FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [FC_W-1:0] FCNT_RELOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [WC_W-1:0] WCNT_LIMIT  = WC_W'(MEM_TIMEOUT);

  state_e           r_state;
  state_e           r_ret_state;
  logic [FC_W-1:0]  r_fcnt;
  logic [WC_W-1:0]  r_wcnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_mem_timeout;

  state_e           w_state_nxt;
  state_e           w_ret_nxt;
  logic [FC_W-1:0]  w_fcnt_nxt;
  logic [WC_W-1:0]  w_wcnt_nxt;
  logic [WC_W-1:0]  w_wcnt_inc;
  state_e           w_eff_state;
  logic             w_hazard;
  ctrl_t            w_ctrl;

  load_use_detect #(
    .REG_W    (REG_W),
    .ZERO_REG (ZERO_REG)
  ) u_load_use_detect (
    .i_id_rn       (i_id_rn),
    .i_id_rm       (i_id_rm),
    .i_id_uses_rm  (i_id_uses_rm),
    .i_ex_mem_read (i_ex_mem_read),
    .i_ex_rd       (i_ex_rd),
    .o_hazard      (w_hazard)
  );

  // On the release cycle of a memory wait the controller behaves exactly as
  // the state it left, so there is no dead cycle after mem_busy drops.
  assign w_eff_state = (r_state == MEM_WAIT) ? r_ret_state : r_state;

  assign w_wcnt_inc = (r_wcnt == {WC_W{1'b1}}) ? r_wcnt : r_wcnt + 1'b1;

  // Output priority mux. Reset forces NOPs into both front-end banks while
  // the whole pipeline keeps clocking, so it fills with bubbles.
  always_comb begin
    w_ctrl = mk_ctrl(1'b1, 1'b0, 1'b0);
    if (i_reset) begin
      w_ctrl = mk_ctrl(1'b1, 1'b1, 1'b1);
    end else if (i_mem_busy) begin
      w_ctrl = mk_ctrl(1'b0, 1'b0, 1'b0);
    end else begin
      case (w_eff_state)
        FLUSH: begin
          // ID holds a squashed instruction, so load-use is irrelevant here.
          w_ctrl = mk_ctrl(1'b1, 1'b0, 1'b1);
        end
        default: begin
          if (i_br_taken) begin
            w_ctrl = mk_ctrl(1'b1, 1'b1, 1'b1);
          end else if (w_hazard) begin
            w_ctrl              = mk_ctrl(1'b1, 1'b1, 1'b0);
            w_ctrl.pc_en        = 1'b0;
            w_ctrl.if_id_en     = 1'b0;
          end
        end
      endcase
    end
  end

  assign o_pc_en        = w_ctrl.pc_en;
  assign o_if_id_en     = w_ctrl.if_id_en;
  assign o_id_ex_en     = w_ctrl.id_ex_en;
  assign o_ex_mem_en    = w_ctrl.ex_mem_en;
  assign o_mem_wb_en    = w_ctrl.mem_wb_en;
  assign o_id_ex_bubble = w_ctrl.id_ex_bubble;
  assign o_if_id_flush  = w_ctrl.if_id_flush;

  // Next-state logic. A memory wait freezes fcnt and remembers where to
  // resume; a branch in the flush window restarts the squash count.
  always_comb begin
    w_state_nxt = r_state;
    w_ret_nxt   = r_ret_state;
    w_fcnt_nxt  = r_fcnt;
    w_wcnt_nxt  = r_wcnt;
    if (i_mem_busy) begin
      w_state_nxt = MEM_WAIT;
      w_wcnt_nxt  = w_wcnt_inc;
      if (r_state != MEM_WAIT) begin
        w_ret_nxt = r_state;
      end
    end else begin
      w_wcnt_nxt = '0;
      case (w_eff_state)
        FLUSH: begin
          if (i_br_taken) begin
            w_state_nxt = FLUSH;
            w_fcnt_nxt  = FCNT_RELOAD;
          end else if (r_fcnt <= FC_W'(1)) begin
            w_state_nxt = RUN;
            w_fcnt_nxt  = '0;
          end else begin
            w_state_nxt = FLUSH;
            w_fcnt_nxt  = r_fcnt - 1'b1;
          end
        end
        default: begin
          w_state_nxt = RUN;
          if (i_br_taken && (FLUSH_CYCLES > 1)) begin
            w_state_nxt = FLUSH;
            w_fcnt_nxt  = FCNT_RELOAD;
          end
        end
      endcase
    end
  end

  // State, counters and the sticky timeout flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= RUN;
      r_ret_state   <= RUN;
      r_fcnt        <= '0;
      r_wcnt        <= '0;
      r_stall_cnt   <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ret_state <= w_ret_nxt;
      r_fcnt      <= w_fcnt_nxt;
      r_wcnt      <= w_wcnt_nxt;
      if (!w_ctrl.pc_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      // Sets on the edge that ends the MEM_TIMEOUT-th busy cycle.
      if (i_mem_busy && (w_wcnt_inc >= WCNT_LIMIT)) begin
        r_mem_timeout <= 1'b1;
      end
    end
  end

  assign o_stall_cnt   = r_stall_cnt;
  assign o_mem_timeout = r_mem_timeout;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_stall_ctrl
// Self-checking bench for pipe_stall_ctrl (REG_W=5, ZERO_REG=31,
// FLUSH_CYCLES=2, MEM_TIMEOUT=64, CNT_W=16). Each stimulus cycle pushes
// its expected outputs to a scoreboard queue; the entry is popped and
// compared once the combinational outputs have settled.
// ---------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

  localparam logic [4:0] ALL  = 5'b11111;
  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] LU   = 5'b00111;

  typedef struct {
    logic [4:0]  en;
    logic        bubble;
    logic        flush;
    logic [15:0] stall;
    logic        timeout;
    bit          chkCnt;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [4:0]  idRn, idRm, exRd;
  logic        idUsesRm, exMemRead, brTaken, memBusy;
  logic        pcEn, ifIdEn, idExEn, exMemEn, memWbEn;
  logic        idExBubble, ifIdFlush;
  logic [15:0] stallCnt;
  logic        memTimeout;

  exp_t        expQ[$];
  logic [15:0] expStall;
  int          compareCount;
  int          failCount;
  int          cycleNo;

  pipe_stall_ctrl #(
    .REG_W        (5),
    .ZERO_REG     (31),
    .FLUSH_CYCLES (2),
    .MEM_TIMEOUT  (64),
    .CNT_W        (16)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_id_rn        (idRn),
    .i_id_rm        (idRm),
    .i_id_uses_rm   (idUsesRm),
    .i_ex_mem_read  (exMemRead),
    .i_ex_rd        (exRd),
    .i_br_taken     (brTaken),
    .i_mem_busy     (memBusy),
    .o_pc_en        (pcEn),
    .o_if_id_en     (ifIdEn),
    .o_id_ex_en     (idExEn),
    .o_ex_mem_en    (exMemEn),
    .o_mem_wb_en    (memWbEn),
    .o_id_ex_bubble (idExBubble),
    .o_if_id_flush  (ifIdFlush),
    .o_stall_cnt    (stallCnt),
    .o_mem_timeout  (memTimeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic sampleOutputs();
    exp_t e;
    if (expQ.size() == 0) begin
      checkOutput($sformatf("c%0d queue", cycleNo), 32'd0, 32'd1);
      return;
    end
    e = expQ.pop_front();
    checkOutput($sformatf("c%0d enables", cycleNo),
                {27'd0, pcEn, ifIdEn, idExEn, exMemEn, memWbEn}, {27'd0, e.en});
    checkOutput($sformatf("c%0d bubble", cycleNo), {31'd0, idExBubble}, {31'd0, e.bubble});
    checkOutput($sformatf("c%0d flush", cycleNo), {31'd0, ifIdFlush}, {31'd0, e.flush});
    if (e.chkCnt) begin
      checkOutput($sformatf("c%0d stall_cnt", cycleNo), {16'd0, stallCnt}, {16'd0, e.stall});
      checkOutput($sformatf("c%0d mem_timeout", cycleNo), {31'd0, memTimeout}, {31'd0, e.timeout});
    end
  endtask

  // Drives one cycle of inputs, records what the outputs must be, then
  // checks them mid-cycle and advances the expected stall count.
  task automatic applyStimulus(input bit rst, input logic [4:0] rn,
                               input logic [4:0] rm, input bit usesRm,
                               input bit memRead, input logic [4:0] rd,
                               input bit br, input bit busy,
                               input logic [4:0] expEn, input bit expBubble,
                               input bit expFlush, input bit expTimeout,
                               input bit chkCnt);
    exp_t e;
    @(negedge clk);
    cycleNo++;
    reset     = rst;
    idRn      = rn;
    idRm      = rm;
    idUsesRm  = usesRm;
    exMemRead = memRead;
    exRd      = rd;
    brTaken   = br;
    memBusy   = busy;
    e.en      = expEn;
    e.bubble  = expBubble;
    e.flush   = expFlush;
    e.stall   = expStall;
    e.timeout = expTimeout;
    e.chkCnt  = chkCnt;
    expQ.push_back(e);
    #1;
    sampleOutputs();
    if (rst) expStall = '0;
    else if (!expEn[4] && expStall != 16'hFFFF) expStall = expStall + 16'd1;
  endtask

  task automatic idle(input bit expTimeout);
    applyStimulus(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, ALL, 0, 0, expTimeout, 1);
  endtask

  initial begin
    compareCount = 0;
    failCount    = 0;
    cycleNo      = 0;
    expStall     = '0;
    reset        = 1'b1;
    idRn         = '0;
    idRm         = '0;
    idUsesRm     = 1'b0;
    exMemRead    = 1'b0;
    exRd         = '0;
    brTaken      = 1'b0;
    memBusy      = 1'b0;

    // Reset held two cycles: pipeline fills with NOPs.
    applyStimulus(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, ALL, 1, 1, 0, 0);
    applyStimulus(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, ALL, 1, 1, 0, 1);
    idle(0);

    // Load-use on rn stalls in the detection cycle, counted one edge later.
    applyStimulus(0, 5'd3, 5'd0, 0, 1, 5'd3, 0, 0, LU, 1, 0, 0, 1);
    applyStimulus(0, 5'd3, 5'd0, 0, 0, 5'd3, 0, 0, ALL, 0, 0, 0, 1);
    // Zero register and unused rm never cause a stall; used rm does.
    applyStimulus(0, 5'd31, 5'd0, 0, 1, 5'd31, 0, 0, ALL, 0, 0, 0, 1);
    applyStimulus(0, 5'd1, 5'd5, 0, 1, 5'd5, 0, 0, ALL, 0, 0, 0, 1);
    applyStimulus(0, 5'd1, 5'd5, 1, 1, 5'd5, 0, 0, LU, 1, 0, 0, 1);

    // Branch with simultaneous load-use: branch wins, two flush cycles.
    applyStimulus(0, 5'd3, 5'd0, 0, 1, 5'd3, 1, 0, ALL, 1, 1, 0, 1);
    applyStimulus(0, 5'd3, 5'd0, 0, 1, 5'd3, 0, 0, ALL, 0, 1, 0, 1);
    idle(0);

    // mem_busy for 3 cycles inside the flush window freezes it.
    applyStimulus(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, ALL, 1, 1, 0, 1);
    repeat (3) applyStimulus(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, NONE, 0, 0, 0, 1);
    applyStimulus(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, ALL, 0, 1, 0, 1);
    idle(0);

    // mem_busy and br_taken together: freeze, branch acts on release.
    applyStimulus(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, NONE, 0, 0, 0, 1);
    applyStimulus(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, ALL, 1, 1, 0, 1);
    applyStimulus(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, ALL, 0, 1, 0, 1);
    idle(0);

    // 70 busy cycles: timeout visible from the 65th cycle and stays sticky.
    for (int i = 1; i <= 70; i++) begin
      applyStimulus(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, NONE, 0, 0, (i >= 65), 1);
    end
    idle(1);
    idle(1);
    idle(1);

    // Reset during a memory wait clears everything.
    repeat (2) applyStimulus(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, NONE, 0, 0, 1, 1);
    applyStimulus(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, ALL, 1, 1, 1, 1);
    idle(0);

    // Reset during the flush window returns straight to RUN.
    applyStimulus(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, ALL, 1, 1, 0, 1);
    applyStimulus(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, ALL, 1, 1, 0, 1);
    idle(0);
    idle(0);

    checkOutput("scoreboard drained", expQ.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Pipeline hazard and stall controller for the five-stage processor. It generates the per-stage enable, bubble and flush signals that drive the enable-gated pipeline register banks, which hold their value when their enable is low. It sits beside the decode stage. It observes decode and execute register fields, branch resolution and data-memory readiness.

## Interface
Parameters:
- REG_W, 5, register-index width
- ZERO_REG, 31, hardwired-zero register index; never a hazard source
- FLUSH_CYCLES, 2, number of fetch-side cycles squashed per taken branch (≥1)
- MEM_TIMEOUT, 64, mem_busy cycles before timeout flag sets
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- id_rn  in  REG_W  first source register of the instruction in ID
- id_rm  in  REG_W  second source register of the instruction in ID
- id_uses_rm  in  1  ID instruction reads id_rm
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  REG_W  destination register of the EX instruction
- br_taken  in  1  branch resolved taken in EX this cycle
- mem_busy  in  1  data memory not ready; MEM access must hold
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register-bank enables
- id_ex_bubble  out  1  load NOP into ID/EX instead of decode output
- if_id_flush  out  1  load NOP into IF/ID
- stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0
- mem_timeout  out  1  sticky; mem_busy exceeded MEM_TIMEOUT

## Operation
- States: RUN, FLUSH, MEM_WAIT. Reset enters RUN. Flush counter fcnt is 0. Wait counter wcnt is 0. stall_cnt is 0. mem_timeout is 0.
- While reset is high: all enables = 1, if_id_flush = 1, id_ex_bubble = 1, so the pipeline fills with NOPs.
- Priority, evaluated combinationally each cycle: mem_busy > br_taken/FLUSH > load-use.
- mem_busy=1, in any state:
  - all five enables = 0, bubble = 0, flush = 0.
  - Next state is MEM_WAIT. The return state is remembered (RUN or FLUSH).
  - wcnt increments, saturating.
  - fcnt is frozen.
- MEM_WAIT with mem_busy=0:
  - outputs are computed as in the return state this same cycle; there is no dead cycle.
  - wcnt clears and the state returns to the remembered state.
- br_taken=1 in RUN:
  - if_id_flush = 1 and id_ex_bubble = 1.
  - All enables = 1.
  - If FLUSH_CYCLES > 1, go to FLUSH with fcnt = FLUSH_CYCLES-1.
- FLUSH:
  - if_id_flush = 1 and enables = 1.
  - fcnt decrements and the state returns to RUN when fcnt reaches 1→0.
  - Load-use is ignored because the ID contents are squashed.
  - br_taken in FLUSH reloads fcnt = FLUSH_CYCLES-1.
- Load-use in RUN: hazard = ex_mem_read & ex_rd≠ZERO_REG & (ex_rd==id_rn | (id_uses_rm & ex_rd==id_rm)).
  - On hazard: pc_en = 0, if_id_en = 0, id_ex_bubble = 1.
  - Other enables = 1. The state stays RUN.
  - There is no stored state; the bubble removes the load from EX the next cycle.
- stall_cnt increments in every cycle with pc_en=0 and reset=0, saturating at all-ones.
- mem_timeout sets when wcnt reaches MEM_TIMEOUT with mem_busy still high. It clears only on reset.

## Timing
- Combinational input→output path for enables, bubble and flush. This has zero latency: the stall acts in the detection cycle.
- State, fcnt, wcnt, stall_cnt and mem_timeout update on the rising clk edge.
- stall_cnt reflects a stall cycle one edge later.
- A taken branch squashes exactly FLUSH_CYCLES IF/ID loads when there is no intervening mem_busy.
- Simultaneous br_taken and load-use: the branch wins; no ID/EX stall.
- Simultaneous mem_busy and br_taken: freeze. br_taken is held stable by the frozen EX stage and acts on the release cycle.
- Reset mid-FLUSH or mid-MEM_WAIT: state RUN and all counters 0 on the next edge.

## Structure
- Package pipe_ctrl_pkg:
  - state enum {RUN, FLUSH, MEM_WAIT}
  - ZERO_REG default constant
  - shared REG_W
- Sub-module load_use_detect: purely combinational hazard compare. It is reused by the forwarding-unit test bench.
- The top module holds the FSM, counters and output priority mux.

## Test plan
- Reset held 2 cycles → all enables 1, flush 1, bubble 1; after release stall_cnt=0, mem_timeout=0, enables 1.
- ex_mem_read=1, ex_rd=3, id_rn=3 → same cycle pc_en=0, if_id_en=0, id_ex_bubble=1; next cycle with ex_mem_read=0 → all enables 1; stall_cnt=1.
- ex_rd=31=id_rn with ex_mem_read=1 → no stall; ex_rd=5=id_rm with id_uses_rm=0 → no stall.
- br_taken one cycle, FLUSH_CYCLES=2 → if_id_flush high exactly 2 cycles, bubble high first cycle only; simultaneous load-use is ignored.
- mem_busy high 3 cycles during FLUSH → all enables 0 for 3 cycles, then the remaining 1 flush cycle completes; stall_cnt +3.
- mem_busy high 70 cycles, MEM_TIMEOUT=64 → mem_timeout rises after cycle 64 and stays high after mem_busy drops, until reset.
